lag_pair_average: RTL and testbench
===================================

// Module: lag_pair_average
// PURPOSE
//   Capture-then-stream lag-pair averager: buffers DEPTH input samples, then emits
//   the round-half-up average of buf[j] and buf[j+LAG] for j = 0..DEPTH-LAG-1.
//   Input and output use valid/ready handshakes. A start pulse re-arms a new frame.
//   Sits between a sample source and a downstream smoothing/decimation consumer.
// PARAMETERS
//   WIDTH  8    sample and result width (bits)
//   DEPTH  128  samples per frame; legal range 2..1024
//   LAG    8    pair distance; legal range 1 <= LAG < DEPTH
//   (derived) NOUT = DEPTH-LAG results per frame; CNT_W = $clog2(DEPTH+1)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset (0 = reset)
//   start      in   1      single-cycle pulse: abort current frame, begin a new FILL
//   in_valid   in   1      data is valid
//   in_ready   out  1      block accepts data; asserted only while in FILL
//   data       in   WIDTH  input sample
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      consumer accepts out_data
//   out_data   out  WIDTH  result
//   done       out  1      frame complete; held high until start or reset
// BEHAVIOUR
//   Reset (async, reset==0): state=FILL, wr_cnt=0, rd_idx=0, out_valid=0, out_data=0,
//     done=0. Sample buffer is not reset; every entry is written before it is read.
//   States: FILL -> EMIT -> DONE. in_ready = (state==FILL), combinational.
//   FILL: on each edge with in_valid, buf[wr_cnt]<=data and wr_cnt++. The edge that
//     accepts sample DEPTH-1 moves to EMIT with rd_idx=0.
//   EMIT: on an edge where (!out_valid || out_ready) && rd_idx<NOUT:
//     out_data <= f(buf[rd_idx], buf[rd_idx+LAG]), out_valid<=1, rd_idx++.
//     When rd_idx==NOUT and (!out_valid || out_ready): out_valid<=0, done<=1,
//     go to DONE. First result is valid 1 cycle after entering EMIT. With out_ready
//     held high, the block emits one result per cycle.
//   Handshake: while out_valid && !out_ready, out_data and out_valid hold stable.
//     Data is transferred when out_valid && out_ready are both high at an edge.
//     Every result is transferred exactly once; none is dropped or duplicated.
//   Arithmetic: sum = a + b at WIDTH+1 bits; avg = (sum>>1) + sum[0], which is
//     round half up. The result never exceeds 2^WIDTH-1, so no saturation is needed.
//   DONE: in_ready=0, out_valid=0, data is ignored.
//   start, in any state: next edge sets state=FILL, wr_cnt=0, rd_idx=0, out_valid=0,
//     done=0. start takes priority over a simultaneous in_valid; that sample is
//     dropped. Any pending output is discarded.
//   Reset mid-frame: applies immediately and asynchronously; the partial frame is lost.
// CONFIGURATION
//   LAG_AVG_DIFF_EN defined: adds input port `mode` (1 bit). mode is latched on the
//     FILL->EMIT edge and applies to the whole frame.
//     mode=0: average as above. mode=1: out_data = |a-b| (WIDTH bits, exact).
//   LAG_AVG_DIFF_EN undefined: no `mode` port; the block computes the average only.
// TESTING
//   1 Reset, then 128 samples data=i (i=0..127) with out_ready=1 -> 120 results
//     out_data=j+4, one per cycle, in order; done=1 after the last result; in_ready=0.
//   2 Rounding with buf[0]=0,buf[8]=1 / buf[1]=255,buf[9]=255 / buf[2]=254,buf[10]=255
//     -> results 1, 255, 255.
//   3 Backpressure: out_ready=0 for 5 cycles while result #10 is valid -> out_data=14
//     holds with out_valid=1; all 120 results arrive, with no loss and no duplicates.
//   4 in_valid toggling 50% during FILL, and data driven during EMIT -> results
//     identical to test 1; EMIT-phase data is ignored (in_ready=0).
//   5 reset=0 asserted at result #50 -> out_valid=0, done=0, in_ready=1 without waiting
//     for a clock; a fresh frame of 128 samples then gives the correct 120 results.
//   6 start in DONE, then a new frame -> correct results. With LAG_AVG_DIFF_EN and
//     mode=1, data=2i gives out_data=16 for all 120 results.

Source files
------------

// File: rtl/lag_pair_average.sv
// lag_pair_average: capture DEPTH samples, then stream the round-half-up average
// of mem[j] and mem[j+LAG] for j = 0..DEPTH-LAG-1 over a valid/ready output.
// Optional build macro LAG_AVG_DIFF_EN adds a `mode` input; mode=1 streams
// |a-b| instead of the average for the whole frame (latched at FILL->EMIT).

// Pair arithmetic: round-half-up average, or absolute difference.
module lag_pair_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             diff_en,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] avg;
  logic [WIDTH-1:0] adiff;

  // (a+b)/2 rounded up on .5; max result is 2^WIDTH-1, so no overflow.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    avg   = sum[WIDTH:1] + WIDTH'(sum[0]);
    adiff = (a >= b) ? (a - b) : (b - a);
    y     = diff_en ? adiff : avg;
  end
endmodule

module lag_pair_average #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  parameter int LAG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             done
`ifdef LAG_AVG_DIFF_EN
  ,
  input  logic             mode
`endif
);
  localparam int NOUT  = DEPTH - LAG;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_FILL, ST_EMIT, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_idx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra, rb;
  logic [WIDTH-1:0] res;
  logic             alu_diff;
  logic             wr_en, last_wr, adv, emit_go, emit_end;

  assign in_ready = (state == ST_FILL);
  assign wr_en    = in_ready && in_valid && !start;
  assign last_wr  = wr_en && (wr_cnt == CNT_W'(DEPTH - 1));
  // Output register may be reloaded when empty or being drained this edge.
  assign adv      = !out_valid || out_ready;
  assign emit_go  = (state == ST_EMIT) && adv && (rd_idx <  CNT_W'(NOUT));
  assign emit_end = (state == ST_EMIT) && adv && (rd_idx == CNT_W'(NOUT));

  // rb wraps harmlessly when rd_idx==NOUT; the read is unused then.
  assign ra = rd_idx[AW-1:0];
  assign rb = ra + AW'(LAG);

`ifdef LAG_AVG_DIFF_EN
  logic mode_q;
  // Frame mode is captured on the edge that completes the fill.
  always_ff @(posedge clk or negedge reset)
    if (!reset)       mode_q <= 1'b0;
    else if (last_wr) mode_q <= mode;
  assign alu_diff = mode_q;
`else
  assign alu_diff = 1'b0;
`endif

  lag_pair_alu #(.WIDTH(WIDTH)) u_alu (
    .a       (mem[ra]),
    .b       (mem[rb]),
    .diff_en (alu_diff),
    .y       (res)
  );

  // Sample buffer: no reset, every entry is written during FILL before use.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_cnt[AW-1:0]] <= data;

  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_FILL;
    else        state <= state_nxt;

  // Next state; start aborts from anywhere.
  always_comb begin
    state_nxt = state;
    if (start) state_nxt = ST_FILL;
    else begin
      case (state)
        ST_FILL: if (last_wr)  state_nxt = ST_EMIT;
        ST_EMIT: if (emit_end) state_nxt = ST_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Counters, output register and done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt    <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else if (start) begin
      wr_cnt    <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (last_wr) rd_idx <= '0;
      if (emit_go) begin
        out_data  <= res;
        out_valid <= 1'b1;
        rd_idx    <= rd_idx + 1'b1;
      end else if (emit_end) begin
        out_valid <= 1'b0;
        done      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lag_pair_average.sv
// Bench for lag_pair_average: directed frames, expected results queued at
// stimulus time and checked by an independent output monitor.
module tb_lag_pair_average;
  localparam int D = 128;
  localparam int L = 8;
  localparam int N = D - L;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_ready, out_valid, out_ready, done;
  logic [7:0] data, out_data;
`ifdef LAG_AVG_DIFF_EN
  logic       mode;
`endif

  lag_pair_average #(.WIDTH(8), .DEPTH(D), .LAG(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done)
`ifdef LAG_AVG_DIFF_EN
    ,
    .mode      (mode)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0, errors = 0;
  int         got = 0, first_cyc = 0, last_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] s [D];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid&ready and no start.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid && out_ready && !start) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra result: got %0d expected none", out_data);
      end else begin
        chk($sformatf("result[%0d]", got), out_data, exp_q.pop_front());
      end
      if (got == 0) first_cyc = cyc;
      last_cyc = cyc;
      got++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input bit diff);
    int a, b;
    for (int j = 0; j < N; j++) begin
      a = s[j]; b = s[j+L];
      if (diff) exp_q.push_back(8'((a > b) ? a - b : b - a));
      else      exp_q.push_back(8'((a + b + 1) / 2));
    end
  endtask

  // Feed one frame; optionally toggle in_valid and keep driving junk afterwards.
  task automatic send_frame(input bit toggle, input bit garbage, input bit diff);
    int i = 0, k = 0;
    got = 0;
    push_exp(diff);
    while (i < D) begin
      if (toggle && (k % 2 == 1)) in_valid = 1'b0;
      else begin in_valid = 1'b1; data = s[i]; end
      @(posedge clk); #1;
      if (in_valid) i++;
      k++;
    end
    in_valid = garbage;
    data     = 8'hAA;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 1000) begin @(posedge clk); #1; n++; end
    chk({name, " done"}, done, 1);
    chk({name, " in_ready"}, in_ready, 0);
    chk({name, " out_valid"}, out_valid, 0);
    chk({name, " leftover"}, exp_q.size(), 0);
    chk({name, " count"}, got, N);
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int target, input string name);
    int n = 0;
    while (got != target && n < 1000) begin @(posedge clk); #1; n++; end
    chk({name, " reached result"}, got, target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start done", done, 0);
    chk("start in_ready", in_ready, 1);
    chk("start out_valid", out_valid, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; data = '0; out_ready = 1'b1;
`ifdef LAG_AVG_DIFF_EN
    mode = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset done", done, 0);
    chk("reset in_ready", in_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: ramp, one result per cycle, out_data = j+4
    for (int i = 0; i < D; i++) s[i] = 8'(i);
    send_frame(0, 0, 0);
    wait_done("t1");
    chk("t1 spacing", last_cyc - first_cyc, N - 1);

    // 2: rounding corners
    pulse_start();
    for (int i = 0; i < D; i++) s[i] = 8'(i);
    s[0] = 8'd0;   s[8]  = 8'd1;
    s[1] = 8'd255; s[9]  = 8'd255;
    s[2] = 8'd254; s[10] = 8'd255;
    send_frame(0, 0, 0);
    wait_done("t2");

    // 3: backpressure while result #10 (=14) is presented
    pulse_start();
    for (int i = 0; i < D; i++) s[i] = 8'(i);
    send_frame(0, 0, 0);
    wait_got(10, "t3");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t3 hold valid c%0d", c), out_valid, 1);
      chk($sformatf("t3 hold data c%0d", c), out_data, 14);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("t3");

    // 4: gappy input, junk driven during EMIT/DONE
    pulse_start();
    send_frame(1, 1, 0);
    wait_done("t4");

    // 5: asynchronous reset mid-stream, then a fresh frame
    pulse_start();
    send_frame(0, 0, 0);
    wait_got(50, "t5");
    reset = 1'b0;
    #1;
    chk("t5 async out_valid", out_valid, 0);
    chk("t5 async done", done, 0);
    chk("t5 async in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_frame(0, 0, 0);
    wait_done("t5");

    // 6: start from DONE, descending data
    pulse_start();
    for (int i = 0; i < D; i++) s[i] = 8'(255 - i);
    send_frame(0, 0, 0);
    wait_done("t6");

`ifdef LAG_AVG_DIFF_EN
    pulse_start();
    mode = 1'b1;
    for (int i = 0; i < D; i++) s[i] = 8'(2 * i);
    send_frame(0, 0, 1);
    wait_done("t6 diff");
    mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
